// File: rtl/lcd_write_scheduler.sv
// lcd_write_scheduler
// Shares the 12864 LCD parallel bus (rs/rw/en/dat) between two requesters.
// Every accepted byte runs SETUP -> PULSE -> HOLD, giving exactly one enable
// pulse; slow commands (clear / home) get a stretched HOLD.
// Optional feature macro: LCD_INIT_SEQ_EN adds the power-on wait and the
// 0x30/0x0C/0x06/0x01 init sequence ahead of any requester traffic.
module lcd_write_scheduler #(
  parameter int unsigned EN_HALF   = 131070,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned LONG_MULT = 8,
  parameter int unsigned POWERUP   = 4000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic       req0_rs,
  input  logic [7:0] req0_dat,
  output logic       req0_ack,
  input  logic       req1_valid,
  input  logic       req1_rs,
  input  logic [7:0] req1_dat,
  output logic       req1_ack,
  output logic       rs,
  output logic       rw,
  output logic       en,
  output logic [7:0] dat,
  output logic       busy
);

  localparam int unsigned HALF_TC = EN_HALF - 1;
  localparam int unsigned LONG_TC = (EN_HALF * LONG_MULT) - 1;

  // Reject parameter sets the phase counter cannot represent
  if ((EN_HALF < 1) || (LONG_MULT < 1) || (POWERUP < 1) || (CNT_W < 1) || (CNT_W > 63) ||
      ((64'(EN_HALF) * 64'(LONG_MULT)) > ((64'd1 << CNT_W) - 64'd1))) begin : g_param_err
    $error("lcd_write_scheduler: invalid EN_HALF/LONG_MULT/POWERUP/CNT_W combination");
  end

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETUP     = 3'd1,
    S_PULSE     = 3'd2,
    S_HOLD      = 3'd3
`ifdef LCD_INIT_SEQ_EN
    ,
    S_INIT_WAIT = 3'd4,
    S_INIT_CMD  = 3'd5
`endif
  } state_t;

`ifdef LCD_INIT_SEQ_EN
  localparam int unsigned PWR_TC     = POWERUP - 1;
  localparam logic [1:0]  INIT_LAST  = 2'd3;
  localparam state_t      S_RESET    = S_INIT_WAIT;
  localparam logic        BUSY_RESET = 1'b1;
`else
  localparam state_t      S_RESET    = S_IDLE;
  localparam logic        BUSY_RESET = 1'b0;
`endif

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_tc;
  logic             w_cnt_done;
  logic             r_last_grant;
  logic             w_last_grant_nxt;
  logic             r_rs;
  logic             w_rs_nxt;
  logic [7:0]       r_dat;
  logic [7:0]       w_dat_nxt;
  logic             r_en;
  logic             w_en_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             r_ack0;
  logic             w_ack0_nxt;
  logic             r_ack1;
  logic             w_ack1_nxt;
  logic             w_slow;
  logic             w_gnt0;
  logic             w_gnt1;

`ifdef LCD_INIT_SEQ_EN
  logic [1:0]       r_init_idx;
  logic [1:0]       w_init_idx_nxt;
  logic             r_init_act;
  logic             w_init_act_nxt;
  logic [7:0]       w_init_byte;
`endif

  // Clear display (0x01) and return home (0x02) need the long HOLD
  assign w_slow = ~r_rs & ((r_dat == 8'h01) | (r_dat == 8'h02));

  // Round robin: r_last_grant==1 means requester 1 was served last
  assign w_gnt0 = req0_valid & (~req1_valid | r_last_grant);
  assign w_gnt1 = req1_valid & (~req0_valid | ~r_last_grant);

`ifdef LCD_INIT_SEQ_EN
  // Init ROM: function set, display on, entry mode, clear
  always_comb begin
    w_init_byte = 8'h30;
    case (r_init_idx)
      2'd0: w_init_byte = 8'h30;
      2'd1: w_init_byte = 8'h0C;
      2'd2: w_init_byte = 8'h06;
      2'd3: w_init_byte = 8'h01;
      default: w_init_byte = 8'h30;
    endcase
  end
`endif

  // Terminal count of the phase counter for the current state
  always_comb begin
    w_tc = CNT_W'(HALF_TC);
    if ((r_state == S_HOLD) && w_slow) begin
      w_tc = CNT_W'(LONG_TC);
    end
`ifdef LCD_INIT_SEQ_EN
    if (r_state == S_INIT_WAIT) begin
      w_tc = CNT_W'(PWR_TC);
    end
`endif
  end

  assign w_cnt_done = (r_cnt == w_tc);

  // Next-state, arbitration and next values of the registered outputs
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = w_cnt_done ? r_cnt : (r_cnt + CNT_W'(1));
    w_last_grant_nxt = r_last_grant;
    w_rs_nxt         = r_rs;
    w_dat_nxt        = r_dat;
    w_ack0_nxt       = 1'b0;
    w_ack1_nxt       = 1'b0;
`ifdef LCD_INIT_SEQ_EN
    w_init_idx_nxt   = r_init_idx;
    w_init_act_nxt   = r_init_act;
`endif

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_gnt0) begin
          w_rs_nxt         = req0_rs;
          w_dat_nxt        = req0_dat;
          w_ack0_nxt       = 1'b1;
          w_last_grant_nxt = 1'b0;
          w_state_nxt      = S_SETUP;
        end else if (w_gnt1) begin
          w_rs_nxt         = req1_rs;
          w_dat_nxt        = req1_dat;
          w_ack1_nxt       = 1'b1;
          w_last_grant_nxt = 1'b1;
          w_state_nxt      = S_SETUP;
        end
      end

      S_SETUP: begin
        if (w_cnt_done) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_PULSE;
        end
      end

      S_PULSE: begin
        if (w_cnt_done) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_HOLD;
        end
      end

      S_HOLD: begin
        if (w_cnt_done) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
`ifdef LCD_INIT_SEQ_EN
          if (r_init_act) begin
            if (r_init_idx == INIT_LAST) begin
              w_init_act_nxt = 1'b0;
            end else begin
              w_init_idx_nxt = r_init_idx + 2'd1;
              w_state_nxt    = S_INIT_CMD;
            end
          end
`endif
        end
      end

`ifdef LCD_INIT_SEQ_EN
      S_INIT_WAIT: begin
        if (w_cnt_done) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_INIT_CMD;
        end
      end

      S_INIT_CMD: begin
        w_cnt_nxt   = '0;
        w_rs_nxt    = 1'b0;
        w_dat_nxt   = w_init_byte;
        w_state_nxt = S_SETUP;
      end
`endif

      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase

    w_en_nxt   = (w_state_nxt == S_PULSE);
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State, counter and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_RESET;
      r_cnt        <= '0;
      r_last_grant <= 1'b1;
      r_rs         <= 1'b0;
      r_dat        <= 8'h00;
      r_en         <= 1'b0;
      r_busy       <= BUSY_RESET;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
`ifdef LCD_INIT_SEQ_EN
      r_init_idx   <= 2'd0;
      r_init_act   <= 1'b1;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_rs         <= w_rs_nxt;
      r_dat        <= w_dat_nxt;
      r_en         <= w_en_nxt;
      r_busy       <= w_busy_nxt;
      r_ack0       <= w_ack0_nxt;
      r_ack1       <= w_ack1_nxt;
`ifdef LCD_INIT_SEQ_EN
      r_init_idx   <= w_init_idx_nxt;
      r_init_act   <= w_init_act_nxt;
`endif
    end
  end

  assign req0_ack = r_ack0;
  assign req1_ack = r_ack1;
  assign rs       = r_rs;
  assign rw       = 1'b0;
  assign en       = r_en;
  assign dat      = r_dat;
  assign busy     = r_busy;

endmodule

// File: tb/tb_lcd_write_scheduler.sv
// Testbench for lcd_write_scheduler (EN_HALF=4, LONG_MULT=3, POWERUP=10).
// Directed requester traffic; a negedge monitor logs acks, enable pulses and
// idle returns, and the directed checks compare them to hand-derived values.
module tb_lcd_write_scheduler;

  localparam int unsigned EN_HALF   = 4;
  localparam int unsigned LONG_MULT = 3;
  localparam int unsigned POWERUP   = 10;
  localparam int unsigned CNT_W     = 8;

`ifdef LCD_INIT_SEQ_EN
  localparam logic BUSY_RST = 1'b1;
`else
  localparam logic BUSY_RST = 1'b0;
`endif

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b0;
  logic       req0_valid = 1'b0;
  logic       req0_rs    = 1'b0;
  logic [7:0] req0_dat   = 8'h00;
  logic       req0_ack;
  logic       req1_valid = 1'b0;
  logic       req1_rs    = 1'b0;
  logic [7:0] req1_dat   = 8'h00;
  logic       req1_ack;
  logic       rs;
  logic       rw;
  logic       en;
  logic [7:0] dat;
  logic       busy;

  lcd_write_scheduler #(
    .EN_HALF   (EN_HALF),
    .CNT_W     (CNT_W),
    .LONG_MULT (LONG_MULT),
    .POWERUP   (POWERUP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_rs    (req0_rs),
    .req0_dat   (req0_dat),
    .req0_ack   (req0_ack),
    .req1_valid (req1_valid),
    .req1_rs    (req1_rs),
    .req1_dat   (req1_dat),
    .req1_ack   (req1_ack),
    .rs         (rs),
    .rw         (rw),
    .en         (en),
    .dat        (dat),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Event logs, emptied while reset is asserted
  int ack_cyc[$];
  int ack_id[$];
  int wr_dat[$];
  int wr_rs[$];
  int wr_len[$];
  int wr_fall[$];
  int idle_cyc[$];
  int ack_bad  = 0;
  int unstable = 0;
  int en_len   = 0;
  logic       prev_en   = 1'b0;
  logic       prev_busy = 1'b0;
  logic       prev_ack0 = 1'b0;
  logic       prev_ack1 = 1'b0;
  logic [7:0] lat_dat   = 8'h00;
  logic       lat_rs    = 1'b0;

  // Bus monitor sampled away from the active edge
  always @(negedge clk) begin
    if (!rst_n) begin
      ack_cyc.delete();
      ack_id.delete();
      wr_dat.delete();
      wr_rs.delete();
      wr_len.delete();
      wr_fall.delete();
      idle_cyc.delete();
      ack_bad   = 0;
      unstable  = 0;
      en_len    = 0;
      prev_en   = en;
      prev_busy = busy;
      prev_ack0 = 1'b0;
      prev_ack1 = 1'b0;
    end else begin
      if (req0_ack) begin ack_cyc.push_back(cyc); ack_id.push_back(0); end
      if (req1_ack) begin ack_cyc.push_back(cyc); ack_id.push_back(1); end
      if ((req0_ack && (prev_ack0 || req1_ack)) || (req1_ack && prev_ack1)) ack_bad++;
      if (en) en_len++;
      if (prev_en && !en) begin
        wr_dat.push_back(int'(dat));
        wr_rs.push_back(int'(rs));
        wr_len.push_back(en_len);
        wr_fall.push_back(cyc);
        en_len = 0;
      end
      if (busy && !prev_busy) begin
        lat_dat = dat;
        lat_rs  = rs;
      end else if (busy && ((dat !== lat_dat) || (rs !== lat_rs))) begin
        unstable++;
      end
      if (!busy && prev_busy) idle_cyc.push_back(cyc);
      prev_en   = en;
      prev_busy = busy;
      prev_ack0 = req0_ack;
      prev_ack1 = req1_ack;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", tag, got, got, exp, exp);
    end
  endtask

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic int count_id(input int id);
    int n = 0;
    foreach (ack_id[k]) if (ack_id[k] == id) n++;
    return n;
  endfunction

  // Present one byte, hold it until ack, then drop valid
  task automatic send(input bit id, input logic rs_i, input logic [7:0] d);
    int   t   = 0;
    logic got = 1'b0;
    if (id == 1'b0) begin req0_rs = rs_i; req0_dat = d; req0_valid = 1'b1; end
    else            begin req1_rs = rs_i; req1_dat = d; req1_valid = 1'b1; end
    while (!got && (t < 200)) begin
      @(negedge clk);
      t++;
      got = (id == 1'b0) ? req0_ack : req1_ack;
    end
    check($sformatf("ack%0d_%02h", id, d), 32'(got), 32'd1);
    if (id == 1'b0) req0_valid = 1'b0;
    else            req1_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while ((busy !== 1'b0) && (t < 100)) begin
      @(negedge clk);
      t++;
    end
    check(tag, 32'(t < 100), 32'd1);
    @(negedge clk);
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int rel;
    repeat (3) @(negedge clk);
    check("rst_en",   32'(en),       32'd0);
    check("rst_rs",   32'(rs),       32'd0);
    check("rst_rw",   32'(rw),       32'd0);
    check("rst_dat",  32'(dat),      32'h00);
    check("rst_ack0", 32'(req0_ack), 32'd0);
    check("rst_ack1", 32'(req1_ack), 32'd0);
    check("rst_busy", 32'(busy),     32'(BUSY_RST));

`ifdef LCD_INIT_SEQ_EN
    // Power-on init sequence precedes the first requester ack
    fork
      send(1'b0, 1'b1, 8'h77);
      begin @(negedge clk); #1 rst_n = 1'b1; rel = cyc; end
    join
    wait_idle("init_idle");
    check("init_b0",    32'(at(wr_dat, 0)), 32'h30);
    check("init_b1",    32'(at(wr_dat, 1)), 32'h0C);
    check("init_b2",    32'(at(wr_dat, 2)), 32'h06);
    check("init_b3",    32'(at(wr_dat, 3)), 32'h01);
    check("init_rs0",   32'(at(wr_rs, 0) + at(wr_rs, 1) + at(wr_rs, 2) + at(wr_rs, 3)), 32'd0);
    check("init_fall0", 32'(at(wr_fall, 0) - rel), 32'd19);
    check("init_ack",   32'(at(ack_cyc, 0) - rel), 32'd71);
    check("init_nack",  32'(ack_cyc.size()), 32'd1);
    check("init_user",  32'(at(wr_dat, 4)), 32'h77);
`else
    // Single write
    do_reset();
    send(1'b0, 1'b1, 8'h35);
    wait_idle("single_idle");
    check("single_nack",   32'(ack_cyc.size()), 32'd1);
    check("single_ackbad", 32'(ack_bad), 32'd0);
    check("single_dat",    32'(at(wr_dat, 0)), 32'h35);
    check("single_rs",     32'(at(wr_rs, 0)), 32'd1);
    check("single_enlen",  32'(at(wr_len, 0)), 32'd4);
    check("single_rise",   32'(at(wr_fall, 0) - at(wr_len, 0) - at(ack_cyc, 0)), 32'd4);
    check("single_toidle", 32'(at(idle_cyc, 0) - at(ack_cyc, 0)), 32'd12);
    check("single_stable", 32'(unstable), 32'd0);
    check("single_keep",   32'(dat), 32'h35);

    // Tie from reset: requester 0 first, then requester 1
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    fork
      send(1'b0, 1'b1, 8'h41);
      send(1'b1, 1'b1, 8'h42);
      begin @(negedge clk); #1 rst_n = 1'b1; end
    join
    wait_idle("tie_idle");
    check("tie_nack",   32'(ack_cyc.size()), 32'd2);
    check("tie_first",  32'(at(ack_id, 0)), 32'd0);
    check("tie_second", 32'(at(ack_id, 1)), 32'd1);
    check("tie_gap",    32'(at(ack_cyc, 1) - at(ack_cyc, 0)), 32'd13);
    check("tie_w0",     32'(at(wr_dat, 0)), 32'h41);
    check("tie_w1",     32'(at(wr_dat, 1)), 32'h42);
    check("tie_ackbad", 32'(ack_bad), 32'd0);

    // Fairness with both requesters continuously valid
    do_reset();
    fork
      begin for (int i = 0; i < 3; i++) send(1'b0, 1'b1, 8'(8'h10 + i)); end
      begin for (int i = 0; i < 3; i++) send(1'b1, 1'b1, 8'(8'h20 + i)); end
    join
    wait_idle("fair_idle");
    check("fair_nack", 32'(ack_cyc.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      int exp_d;
      exp_d = ((i % 2) == 0) ? (16 + i / 2) : (32 + i / 2);
      check($sformatf("fair_id%0d", i),  32'(at(ack_id, i)), 32'(i % 2));
      check($sformatf("fair_dat%0d", i), 32'(at(wr_dat, i)), 32'(exp_d));
    end
    for (int i = 0; i < 5; i++)
      check($sformatf("fair_gap%0d", i), 32'(at(ack_cyc, i + 1) - at(ack_cyc, i)), 32'd13);
    check("fair_stable", 32'(unstable), 32'd0);

    // Slow commands stretch HOLD; data 0x01 and command 0x03 do not
    do_reset();
    send(1'b1, 1'b0, 8'h01);
    wait_idle("slow1_idle");
    check("slow1_enlen", 32'(at(wr_len, 0)), 32'd4);
    check("slow1_hold",  32'(at(idle_cyc, 0) - at(wr_fall, 0)), 32'd12);
    check("slow1_total", 32'(at(idle_cyc, 0) - at(ack_cyc, 0)), 32'd20);
    send(1'b1, 1'b0, 8'h02);
    wait_idle("slow2_idle");
    check("slow2_total", 32'(at(idle_cyc, 1) - at(ack_cyc, 1)), 32'd20);
    send(1'b1, 1'b1, 8'h01);
    wait_idle("data01_idle");
    check("data01_total", 32'(at(idle_cyc, 2) - at(ack_cyc, 2)), 32'd12);
    send(1'b0, 1'b0, 8'h03);
    wait_idle("cmd03_idle");
    check("cmd03_total", 32'(at(idle_cyc, 3) - at(ack_cyc, 3)), 32'd12);
    check("slow_stable", 32'(unstable), 32'd0);

    // Reset during PULSE abandons the byte; pending requester served after
    do_reset();
    send(1'b0, 1'b1, 8'h55);
    fork send(1'b1, 1'b1, 8'h66); join_none
    repeat (5) @(negedge clk);
    check("rp_en_before", 32'(en), 32'd1);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("rp_en",   32'(en),       32'd0);
    check("rp_dat",  32'(dat),      32'h00);
    check("rp_rs",   32'(rs),       32'd0);
    check("rp_busy", 32'(busy),     32'd0);
    check("rp_ack",  32'(req0_ack | req1_ack), 32'd0);
    #1 rst_n = 1'b1;
    wait fork;
    wait_idle("rp_idle");
    check("rp_nack0", 32'(count_id(0)), 32'd0);
    check("rp_nack1", 32'(count_id(1)), 32'd1);
    check("rp_nwr",   32'(wr_dat.size()), 32'd1);
    check("rp_dat1",  32'(at(wr_dat, 0)), 32'h66);
    check("rp_len1",  32'(at(wr_len, 0)), 32'd4);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
